// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and widths for the MIPS multiply/divide unit
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdState_t;

endpackage

// File: rtl/md_negate.sv
// rtl/md_negate.sv - conditional two's-complement negate, used for operand magnitudes and result sign fix
module md_negate #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - 33-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO
module mul_div_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] mt_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdState_t state, nextState;

  logic [4:0]        cnt;
  logic [XLEN-1:0]   opMag;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   rawA;
  logic [2*XLEN-1:0] prod;
  logic              opIsDiv, negQ, negR, divZero, doneReg;

  logic              startIsDiv, startSigned;
  logic [XLEN-1:0]   magA, magB, quotFix, remFix;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN:0]     mulSum, remShift;
  logic [XLEN-1:0]   remSub;
  logic              divTake;

  assign startIsDiv  = (op == MD_DIV) || (op == MD_DIVU);
  assign startSigned = (op == MD_MULT) || (op == MD_DIV);

  md_negate #(.W(XLEN)) uNegA (.a(rs_data), .neg(startSigned & rs_data[XLEN-1]), .y(magA));
  md_negate #(.W(XLEN)) uNegB (.a(rt_data), .neg(startSigned & rt_data[XLEN-1]), .y(magB));
  md_negate #(.W(2*XLEN)) uNegProd (.a(prod), .neg(negQ), .y(prodFix));
  md_negate #(.W(XLEN)) uNegQuot (.a(prod[XLEN-1:0]), .neg(negQ), .y(quotFix));
  md_negate #(.W(XLEN)) uNegRem (.a(rem), .neg(negR), .y(remFix));

  // Multiply: prod holds {accumulator, remaining multiplier bits}; divide: prod[XLEN-1:0] shifts dividend out, quotient in.
  assign mulSum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opMag} : '0);
  assign remShift = {rem, prod[XLEN-1]};
  assign divTake  = remShift >= {1'b0, opMag};
  assign remSub   = remShift[XLEN-1:0] - opMag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (start) nextState = startIsDiv ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (cnt == 5'd31) nextState = ST_FIX;
      ST_FIX:  nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = doneReg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      opMag   <= '0;
      rem     <= '0;
      rawA    <= '0;
      prod    <= '0;
      opIsDiv <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
      doneReg <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt     <= '0;
            opMag   <= startIsDiv ? magB : magA;
            prod    <= {{XLEN{1'b0}}, (startIsDiv ? magA : magB)};
            rem     <= '0;
            rawA    <= rs_data;
            opIsDiv <= startIsDiv;
            negQ    <= startSigned & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
            negR    <= startSigned & rs_data[XLEN-1];
            divZero <= startIsDiv && (rt_data == '0);
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        ST_MUL: begin
          prod <= {mulSum, prod[XLEN-1:1]};
          cnt  <= cnt + 5'd1;
        end
        ST_DIV: begin
          rem              <= divTake ? remSub : remShift[XLEN-1:0];
          prod[XLEN-1:0]   <= {prod[XLEN-2:0], divTake};
          cnt              <= cnt + 5'd1;
        end
        ST_FIX: begin
          doneReg <= 1'b1;
          if (divZero) begin
            hi <= rawA;
            lo <= '1;
          end else if (opIsDiv) begin
            hi <= remFix;
            lo <= quotFix;
          end else begin
            hi <= prodFix[2*XLEN-1:XLEN];
            lo <= prodFix[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the register file: it takes the two register read ports (rs, rt) as operands and executes MULT, MULTU, DIV and DIVU over 33 cycles. It also services MTHI/MTLO writes. HI/LO are exposed continuously for MFHI/MFLO, and a busy flag lets the control unit stall.

## Interface
Parameters: none (width fixed at 32).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  launch operation `op` this cycle (accepted only when busy=0)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  32  operand A / dividend (register file ReadData1)
- rt_data  in  32  operand B / divisor (register file ReadData2)
- mthi  in  1  write mt_data to HI (idle only)
- mtlo  in  1  write mt_data to LO (idle only)
- mt_data  in  32  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO just updated by a completed op
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset: hi=0, lo=0, busy=0, done=0; state IDLE; iteration counter=0. Reset asserted mid-operation aborts it; HI/LO return to 0.
- States:
  - IDLE: wait for start.
  - MUL: 32 iterations, shift-add.
  - DIV: 32 iterations, restoring division on a 33-bit partial remainder.
  - FIX: sign correction, HI/LO write.
- Transitions:
  - IDLE→MUL/DIV on start.
  - MUL/DIV→FIX when the counter reaches 31.
  - FIX→IDLE always.
- On start: latch operands as magnitudes. For MULT/DIV, negative operands are negated; for U ops they are used raw. Also latch neg_q = signA^signB and neg_r = signA (signed ops only; 0 for unsigned).
- Multiply: 64-bit product of the magnitudes. In FIX, negate all 64 bits if neg_q. HI = product[63:32], LO = product[31:0].
- Divide: quotient and remainder of the magnitudes. In FIX, LO = neg_q ? −q : q and HI = neg_r ? −r : r (truncating division; remainder takes the dividend's sign).
- Divisor zero (DIV or DIVU): still takes full latency. HI = rs_data as latched, LO = 32'hFFFFFFFF; no sign fix.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude path; no special case.
- start while busy=1: ignored; in-flight op unaffected.
- mthi/mtlo while busy=1: ignored.
- mthi/mtlo in the same cycle as an accepted start: ignored; start wins.
- mthi and mtlo together while idle: both written.
- HI/LO change only on reset, in FIX, or on an accepted mthi/mtlo.

## Timing
- start sampled at edge N. After N: busy=1.
- Iterations occupy edges N+1..N+32.
- FIX at edge N+33: HI/LO updated, done=1, busy=0.
- Latency: 33 cycles from accept to result visible. A new start is accepted in the cycle done=1 (back-to-back throughput 34 cycles).
- done is high for exactly one cycle after edge N+33.
- mthi/mtlo take effect at the next edge; hi/lo outputs are registered, with no combinational path from inputs.
- busy is a registered output.

## Structure
- Shared package mips_pkg:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - state encoding ST_IDLE/ST_MUL/ST_DIV/ST_FIX (2 bits)
  - width constant 32
- One sub-module is natural: md_negate, a conditional 64-bit two's-complement negate. It serves both operand-magnitude capture and FIX.
- Everything else is a single sequential process plus next-state logic in mul_div_unit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulses once, busy low.
- MULT −3 × 7 (0xFFFFFFFD, 0x00000007) → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → HI=5, LO=0xFFFFFFFF after 33 cycles.
- start (DIVU 100/7) with a second start at cycle 10 plus mthi=1 (mt_data=0x1234) mid-op → result HI=2, LO=14; second start and mthi ignored. mthi 0x1234 when idle → HI=0x1234 next cycle.
- Reset asserted at cycle 15 of a MULT → busy=0, done=0, HI=LO=0 immediately. A new start after release completes normally.
